// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IFU, LSU and memory-port signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_rdata;
  logic                  ifu_resp_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_rdata;
  logic                  lsu_resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter for one memory port with watchdog
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant;   // 1 = LSU
  logic                owner;        // 1 = LSU
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic                ifu_err_q, lsu_err_q;

  logic                grant_ifu, grant_lsu, accept, timeout, done;
  logic                ifu_ready, lsu_ready, mreq_valid, ifu_rvalid, lsu_rvalid;
  logic [DATA_W-1:0]   rdata_n;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_grant);
    grant_lsu = bus.lsu_req_valid && !grant_ifu;
    accept    = (state == IDLE) && (grant_ifu || grant_lsu);
    timeout   = (cnt == CNT_W'(TIMEOUT - 1));
    done      = bus.mem_resp_valid || timeout;
    rdata_n   = (bus.mem_resp_valid && !wen_q) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ifu_ready  = 1'b0;
    lsu_ready  = 1'b0;
    mreq_valid = 1'b0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    case (state)
      IDLE: begin
        ifu_ready = grant_ifu && rst;
        lsu_ready = grant_lsu && rst;
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        mreq_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (done) state_nxt = RESP;
      end
      RESP: begin
        ifu_rvalid = !owner;
        lsu_rvalid = owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt         <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant_lsu;
            last_grant <= grant_lsu;
            addr_q     <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q      <= grant_lsu && bus.lsu_wen;
            wdata_q    <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q    <= grant_lsu ? bus.lsu_wmask : '0;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) cnt <= '0;
        end
        WAIT: begin
          // A response arriving on the timeout cycle still counts as a response.
          if (done) begin
            if (owner) begin
              lsu_rdata_q <= rdata_n;
              lsu_err_q   <= !bus.mem_resp_valid;
            end else begin
              ifu_rdata_q <= rdata_n;
              ifu_err_q   <= !bus.mem_resp_valid;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = ifu_rvalid;
  assign bus.lsu_resp_valid = lsu_rvalid;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.ifu_resp_err   = ifu_err_q;
  assign bus.lsu_resp_err   = lsu_err_q;
  assign bus.mem_req_valid  = mreq_valid;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE, check the grant and leave the DUT in REQ.
  task automatic issue(input bit lsu, input logic [31:0] addr, input bit wen,
                       input logic [31:0] wdata, input logic [3:0] wmask, input string tag);
    if (lsu) begin
      bus.lsu_req_valid = 1'b1; bus.lsu_addr = addr; bus.lsu_wen = wen;
      bus.lsu_wdata = wdata; bus.lsu_wmask = wmask;
    end else begin
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = addr;
    end
    #1;
    check({tag, "_ready"}, lsu ? bus.lsu_req_ready : bus.ifu_req_ready, 1);
    check({tag, "_other_ready"}, lsu ? bus.ifu_req_ready : bus.lsu_req_ready, 0);
    step();
    if (lsu) bus.lsu_req_valid = 1'b0;
    else     bus.ifu_req_valid = 1'b0;
  endtask

  // Drive the memory side from REQ through RESP and check the routed response.
  task automatic complete(input bit lsu, input logic [31:0] addr, input bit wen,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input int rdy_dly, input int rsp_dly, input logic [31:0] mrdata,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_wait,
                          input string tag);
    int waited;
    bit got;
    for (int i = 0; i <= rdy_dly; i++) begin
      check({tag, "_mreq_valid"}, bus.mem_req_valid, 1);
      check({tag, "_mem_addr"}, bus.mem_addr, addr);
      check({tag, "_mem_wen"}, bus.mem_wen, wen);
      check({tag, "_mem_wmask"}, bus.mem_wmask, wmask);
      if (lsu) check({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
      check({tag, "_busy_ready"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      if (i == rdy_dly) bus.mem_req_ready = 1'b1;
      step();
    end
    bus.mem_req_ready = 1'b0;
    check({tag, "_mreq_drop"}, bus.mem_req_valid, 0);
    waited = 0;
    got = 1'b0;
    while (!got && waited < TO + 4) begin
      if (waited == rsp_dly) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = mrdata;
      end
      step();
      bus.mem_resp_valid = 1'b0;
      waited++;
      got = lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid;
    end
    check({tag, "_resp_seen"}, got, 1);
    check({tag, "_wait_cycles"}, waited, exp_wait);
    check({tag, "_rdata"}, lsu ? bus.lsu_rdata : bus.ifu_rdata, exp_rdata);
    check({tag, "_err"}, lsu ? bus.lsu_resp_err : bus.ifu_resp_err, exp_err);
    check({tag, "_other_resp"}, lsu ? bus.ifu_resp_valid : bus.lsu_resp_valid, 0);
    step();
    check({tag, "_resp_pulse"}, lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 0);
  endtask

  logic [31:0] arb_ia [2] = '{32'h8000_0004, 32'h8000_0008};
  logic [31:0] arb_id [2] = '{32'h1111_1111, 32'h3333_3333};
  logic [31:0] arb_la [2] = '{32'h8000_2000, 32'h8000_2004};
  logic [31:0] arb_ld [2] = '{32'h2222_2222, 32'h4444_4444};

  initial begin
    bus.ifu_req_valid = 0; bus.ifu_addr = '0;
    bus.lsu_req_valid = 0; bus.lsu_addr = '0; bus.lsu_wen = 0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mreq_valid", bus.mem_req_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    check("rst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    rst = 1'b1;
    step();

    // Tie from reset: IFU first, then LSU, then alternation repeats.
    for (int r = 0; r < 2; r++) begin
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = arb_ia[r];
      bus.lsu_req_valid = 1'b1; bus.lsu_addr = arb_la[r];
      bus.lsu_wen = 1'b0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
      #1;
      check("arb_tie_ifu_ready", bus.ifu_req_ready, 1);
      check("arb_tie_lsu_ready", bus.lsu_req_ready, 0);
      step();
      bus.ifu_req_valid = 1'b0;
      complete(0, arb_ia[r], 0, 0, 0, 0, 0, arb_id[r], arb_id[r], 0, 1, "arb_ifu");
      check("arb_lsu_ready", bus.lsu_req_ready, 1);
      step();
      bus.lsu_req_valid = 1'b0;
      complete(1, arb_la[r], 0, 0, 0, 0, 0, arb_ld[r], arb_ld[r], 0, 1, "arb_lsu");
    end

    issue(0, 32'h8000_0000, 0, 0, 0, "ifu_rd");
    complete(0, 32'h8000_0000, 0, 0, 0, 0, 1, 32'h0000_0413, 32'h0000_0413, 0, 2, "ifu_rd");

    issue(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, "lsu_wr");
    complete(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'hCAFE_F00D, 0, 0, 1, "lsu_wr");

    issue(1, 32'h8000_3000, 0, 0, 0, "tmo");
    complete(1, 32'h8000_3000, 0, 0, 0, 0, -1, 0, 0, 1, TO, "tmo");

    issue(0, 32'h8000_0020, 0, 0, 0, "post_tmo");
    complete(0, 32'h8000_0020, 0, 0, 0, 0, 0, 32'h0011_2233, 32'h0011_2233, 0, 1, "post_tmo");

    issue(0, 32'h8000_0040, 0, 0, 0, "coinc");
    complete(0, 32'h8000_0040, 0, 0, 0, 0, TO - 1, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 0, TO, "coinc");

    // Asynchronous reset in the middle of WAIT, then a stale memory response.
    issue(0, 32'h8000_0080, 0, 0, 0, "mid_rst");
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mreq_valid", bus.mem_req_valid, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_ifu_rdata", bus.ifu_rdata, 0);
    check("mid_rst_lsu_err", bus.lsu_resp_err, 0);
    check("mid_rst_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    step();
    bus.mem_resp_valid = 1'b0;
    check("late_resp_ignored", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    check("late_mreq_valid", bus.mem_req_valid, 0);
    step();
    check("late_resp_ignored2", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);

    issue(0, 32'h8000_0100, 0, 0, 0, "after_rst");
    complete(0, 32'h8000_0100, 0, 0, 0, 0, 0, 32'h0000_0013, 32'h0000_0013, 0, 1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
